// File: rtl/mpu_host_driver.sv
// Host-side driver for the matrix-unit control FSM: buffers LOAD bytes, issues instructions
// with FSM-aligned timing, streams 64 bytes in lockstep and returns UNLOAD bytes over a read port.
module mpu_host_driver #(
  parameter int BYTES   = 64,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_instr,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic [7:0] fsm_instr,
  input  logic       fsm_busy,
  output logic [7:0] load_byte,
  input  logic [7:0] unload_byte,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    STREAM,
    WAIT_HI,
    WAIT_LO,
    DRAIN
  } state_t;

  localparam int         AW        = $clog2(BYTES);
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [6:0] LAST      = 7'(BYTES - 1);
  localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;

  state_t        state, state_nx;
  logic [7:0]    instr_q, instr_nx;
  logic [6:0]    cnt, cnt_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          done_nx, err_nx;
  logic          live;
  logic          fill_we, unl_we;
  logic [3:0]    cmd_op, lat_op;
  logic [7:0]    mem [BYTES];

  assign cmd_op = cmd_instr[3:0];
  assign lat_op = instr_q[3:0];

  // live keeps cmd_ready low while reset is held, even if the FSM drops busy early
  assign cmd_ready = live && (state == IDLE) && !fsm_busy;
  assign wr_ready  = (state == FILL);
  assign rd_valid  = (state == DRAIN);
  assign rd_data   = rd_valid ? mem[cnt[AW-1:0]] : 8'h00;
  assign load_byte = (state == STREAM) ? mem[cnt[AW-1:0]] : 8'h00;
  assign fsm_instr = (state == ISSUE) ? instr_q : {instr_q[7:4], 4'b0000};

  always_comb begin
    state_nx = state;
    instr_nx = instr_q;
    cnt_nx   = cnt;
    timer_nx = timer;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    fill_we  = 1'b0;
    unl_we   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // NA ops are completed locally and never latched, so DD/AA on the FSM stay put
          if (cmd_op[3:2] == 2'b00) begin
            done_nx = 1'b1;
          end else begin
            instr_nx = cmd_instr;
            cnt_nx   = '0;
            state_nx = (cmd_op == OP_LOAD) ? FILL : ISSUE;
          end
        end
      end
      FILL: begin
        if (wr_valid) begin
          fill_we = 1'b1;
          cnt_nx  = cnt + 7'd1;
          if (cnt == LAST) begin
            cnt_nx   = '0;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        timer_nx = '0;
        state_nx = (lat_op == OP_LOAD || lat_op == OP_UNLOAD) ? STREAM : WAIT_HI;
      end
      STREAM: begin
        unl_we = (lat_op == OP_UNLOAD);
        cnt_nx = cnt + 7'd1;
        if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = WAIT_LO;
        end
      end
      WAIT_HI: begin
        if (fsm_busy) begin
          state_nx = WAIT_LO;
        end else if (timer == TLAST) begin
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!fsm_busy) begin
          cnt_nx = '0;
          if (lat_op == OP_UNLOAD) begin
            state_nx = DRAIN;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          cnt_nx = cnt + 7'd1;
          if (cnt == LAST) begin
            cnt_nx   = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      instr_q <= 8'h00;
      cnt     <= '0;
      timer   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      live    <= 1'b0;
    end else begin
      state   <= state_nx;
      instr_q <= instr_nx;
      cnt     <= cnt_nx;
      timer   <= timer_nx;
      done    <= done_nx;
      err     <= err_nx;
      live    <= 1'b1;
    end
  end

  // Byte buffer carries no reset; every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt[AW-1:0]] <= wr_data;
    end else if (unl_we) begin
      mem[cnt[AW-1:0]] <= unload_byte;
    end
  end

endmodule
